alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 32-bit ALU between two requesters (0: fetch/PC-update unit, 1: execute stage).
//  Accepts one operation at a time by valid/ready handshake, drives registered operands to the ALU,
//  waits ALU_LAT cycles, and returns result and flag on a shared response channel tagged by requester ID.
//  Sits between the pipeline control logic and the ALU instance.
// PARAMETERS
//  WIDTH    32  operand/result width
//  ALU_LAT  1   cycles from registered operands to sampling ALU outputs; legal 1..15
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  req0_valid   in   1      requester 0 has an operation pending
//  req0_ready   out  1      requester 0 operation accepted this cycle
//  req0_a       in   WIDTH  operand a
//  req0_b       in   WIDTH  operand b
//  req0_op      in   3      ALU opcode: ADD 000, AND 001, OR 010, SHIFT 011, NEG 100, NOT 101, SUB 110, COMP 111
//  req1_valid/req1_ready/req1_a/req1_b/req1_op  same as requester 0
//  alu_a        out  WIDTH  registered operand a to ALU
//  alu_b        out  WIDTH  registered operand b to ALU
//  alu_op       out  3      registered opcode to ALU
//  alu_r        in   WIDTH  ALU result
//  alu_flag     in   1      ALU overflow output (less-than for COMP, 0 otherwise)
//  resp_valid   out  1      response available
//  resp_ready   in   1      consumer takes response
//  resp_id      out  1      requester that owns the response
//  resp_r       out  WIDTH  captured result
//  resp_flag    out  1      captured flag
// BEHAVIOUR
//  Reset: state=IDLE; alu_a/alu_b/resp_r=0; alu_op=000; resp_valid/resp_id/resp_flag=0; cnt=0; last_grant=1.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: grant computed combinationally from valids.
//   Grant rule: only one valid -> that one; both valid -> requester != last_grant (round-robin).
//   reqN_ready = (state==IDLE) & grant==N & reqN_valid; never both high.
//   On accept: latch a/b/op into alu_*, owner<=N, last_grant<=N, cnt<=ALU_LAT-1, ->BUSY.
//  BUSY: cnt decrements each cycle; when cnt==0 capture alu_r->resp_r and alu_flag->resp_flag,
//   resp_id<=owner, resp_valid<=1, ->DONE. First response is 1+ALU_LAT cycles after the accept edge.
//  DONE: resp_* held stable while resp_valid & !resp_ready. On resp_valid&resp_ready:
//   resp_valid<=0, ->IDLE. No accept in the handshake cycle; next accept is earliest the following cycle.
//   Throughput is one operation per ALU_LAT+2 cycles.
//  Requesters hold a/b/op stable while valid until ready. A dropped valid before ready is legal; nothing is latched.
//  alu_* outputs hold their last values outside BUSY. The ALU is never re-driven mid-operation.
//  Flag passes through unmodified; no width extension. Result is WIDTH bits, with no saturation.
//  Reset mid-operation (any state) aborts the transaction; no response is ever issued for it.
//  The response consumer must not depend on resp_r while resp_valid=0.
// CONFIGURATION
//  ALU_ARB_FIXED_PRI_EN defined: requester 0 always wins when both are valid. last_grant is not used for arbitration.
//  Not defined (default): round-robin as above.
// TESTING
//  1. Single req0 ADD a=5 b=7, resp_ready=1 -> req0_ready 1 cycle; resp_valid 2 cycles later; resp_id=0 r=12 flag=0.
//  2. Both valid from reset: req0 SUB 10-3, req1 OR F0|0F -> req0 served first (r=7), then req1 (r=FF, id=1).
//     Under FIXED_PRI with req0 kept valid, req1 starves.
//  3. req1 COMP a=3 b=9 -> r=0 flag=1; COMP a=9 b=9 -> r=1 flag=0.
//  4. resp_ready=0 for 5 cycles in DONE -> resp_* stable and no req_ready asserted. Release -> IDLE next cycle.
//  5. ALU_LAT=3: accept at cycle t -> resp_valid rises at t+4. rst_n low during BUSY -> resp_valid stays 0.
//     Next request is served normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester valid/ready arbiter in front of a shared ALU.
// Ports: clk, rst_n; req0_*/req1_* (valid, ready, a, b, op) requester channels;
//   alu_a/alu_b/alu_op registered ALU operands, alu_r/alu_flag ALU results;
//   resp_valid/resp_ready/resp_id/resp_r/resp_flag shared response channel.
// Option: define ALU_ARB_FIXED_PRI_EN for fixed priority (req0 wins),
//   otherwise round-robin between the two requesters.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_flag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_r,
  output logic             resp_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t     state;
  state_t     state_nx;
  logic       grant;
  logic       accept;
  logic       cap;
  logic       owner;
  logic [3:0] cnt;

`ifdef ALU_ARB_FIXED_PRI_EN
  always_comb grant = ~req0_valid;
`else
  logic last_grant;

  // Contention goes to whoever was not served last.
  always_comb begin
    grant = 1'b0;
    unique case ({req1_valid, req0_valid})
      2'b11:   grant = ~last_grant;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (accept)
      last_grant <= grant;
  end
`endif

  assign req0_ready = (state == IDLE) & ~grant & req0_valid;
  assign req1_ready = (state == IDLE) & grant & req1_valid;
  assign accept     = req0_ready | req1_ready;
  assign cap        = (state == BUSY) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (cap) state_nx = DONE;
      DONE:    if (resp_valid && resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 3'b000;
      owner      <= 1'b0;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_r     <= '0;
      resp_flag  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= grant ? req1_a : req0_a;
        alu_b  <= grant ? req1_b : req0_b;
        alu_op <= grant ? req1_op : req0_op;
        owner  <= grant;
        cnt    <= CNT_INIT;
      end
      if (state == BUSY) begin
        if (cap) begin
          resp_r     <= alu_r;
          resp_flag  <= alu_flag;
          resp_id    <= owner;
          resp_valid <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
      if ((state == DONE) && resp_valid && resp_ready)
        resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a behavioural ALU.
// Reference model tracks transactions by cycle timestamps.
module tb_alu_arbiter;

  localparam int W   = 32;
  localparam int LAT = 3;

  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] OR_  = 3'd2;
  localparam logic [2:0] SUB  = 3'd6;
  localparam logic [2:0] COMP = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic [2:0]   req0_op;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [2:0]   req1_op;
  logic [W-1:0] alu_a, alu_b, alu_r;
  logic [2:0]   alu_op;
  logic         alu_flag;
  logic         resp_valid, resp_ready, resp_id, resp_flag;
  logic [W-1:0] resp_r;

  alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_flag(alu_flag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_r(resp_r), .resp_flag(resp_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] alu_fn(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic        f;
    r = '0;
    f = 1'b0;
    case (op)
      3'd0: begin
        r = a + b;
        f = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a << b[4:0];
      3'd4: r = -a;
      3'd5: r = ~a;
      3'd6: begin
        r = a - b;
        f = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: begin
        r = {31'b0, a == b};
        f = $signed(a) < $signed(b);
      end
    endcase
    return {f, r};
  endfunction

  assign {alu_flag, alu_r} = alu_fn(alu_op, alu_a, alu_b);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  bit          m_busy;
  int          m_resp_at;
  logic [31:0] m_r, m_a, m_b;
  logic [2:0]  m_op;
  bit          m_f, m_id, m_lastg;
  int          cyc;
  int          resp_count;
  int          got_cyc, acc_cyc;
  logic [31:0] got_r;
  bit          got_f, got_id;
  bit          acc_any;

  task automatic step();
    bit ev, w, a0, a1;
    #1;
    ev = m_busy && (cyc >= m_resp_at);
    check("resp_valid", 32'(resp_valid), 32'(ev));
    if (ev) begin
      check("resp_id", 32'(resp_id), 32'(m_id));
      check("resp_r", resp_r, m_r);
      check("resp_flag", 32'(resp_flag), 32'(m_f));
    end
    if (m_busy) begin
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_op", 32'(alu_op), 32'(m_op));
    end
`ifdef ALU_ARB_FIXED_PRI_EN
    w = !req0_valid;
`else
    w = (req0_valid && req1_valid) ? !m_lastg : req1_valid;
`endif
    a0 = !m_busy && rst_n && req0_valid && !w;
    a1 = !m_busy && rst_n && req1_valid && w;
    check("req0_ready", 32'(req0_ready), 32'(a0));
    check("req1_ready", 32'(req1_ready), 32'(a1));
    acc_any = a0 || a1;
    if (ev && resp_ready && rst_n) begin
      got_r   = resp_r;
      got_f   = resp_flag;
      got_id  = resp_id;
      got_cyc = cyc;
      resp_count++;
      m_busy  = 1'b0;
    end
    if (acc_any) begin
      m_busy    = 1'b1;
      m_resp_at = cyc + 1 + LAT;
      m_id      = a1;
      m_lastg   = a1;
      m_a       = a1 ? req1_a : req0_a;
      m_b       = a1 ? req1_b : req0_b;
      m_op      = a1 ? req1_op : req0_op;
      {m_f, m_r} = alu_fn(m_op, m_a, m_b);
      acc_cyc   = cyc;
    end
    cyc++;
    @(negedge clk);
    if (a0) req0_valid = 1'b0;
    if (a1) req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    m_busy     = 1'b0;
    m_lastg    = 1'b1;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_r", resp_r, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_flag", 32'(resp_flag), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input bit id, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic wait_resp(input int max);
    int tgt;
    tgt = resp_count + 1;
    for (int i = 0; i < max && resp_count < tgt; i++) step();
    check("resp_wait", 32'(resp_count), 32'(tgt));
  endtask

  task automatic rand_req(input bit id);
    logic [31:0] a, b;
    a = $urandom;
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = $urandom_range(0, 40);
      default: b = $urandom;
    endcase
    set_req(id, 3'($urandom_range(0, 7)), a, b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    resp_ready = 1'b1;
    cyc = 0; resp_count = 0;
    @(negedge clk);
    do_reset();

    set_req(0, ADD, 32'd5, 32'd7);
    wait_resp(20);
    check("t1_r", got_r, 32'd12);
    check("t1_id", 32'(got_id), 32'd0);
    check("t1_flag", 32'(got_f), 32'd0);
    check("t1_lat", 32'(got_cyc - acc_cyc), 32'(LAT + 1));

    do_reset();
    set_req(0, SUB, 32'd10, 32'd3);
    set_req(1, OR_, 32'hF0, 32'h0F);
    wait_resp(20);
    check("t2_id0", 32'(got_id), 32'd0);
    check("t2_r0", got_r, 32'd7);
    wait_resp(20);
    check("t2_id1", 32'(got_id), 32'd1);
    check("t2_r1", got_r, 32'hFF);

    set_req(1, COMP, 32'd3, 32'd9);
    wait_resp(20);
    check("t3_lt_r", got_r, 32'd0);
    check("t3_lt_f", 32'(got_f), 32'd1);
    set_req(1, COMP, 32'd9, 32'd9);
    wait_resp(20);
    check("t3_eq_r", got_r, 32'd1);
    check("t3_eq_f", 32'(got_f), 32'd0);

    resp_ready = 1'b0;
    set_req(0, ADD, 32'd1, 32'd2);
    for (int i = 0; i < 20 && !(m_busy && cyc >= m_resp_at); i++) step();
    set_req(1, OR_, 32'h1, 32'h2);
    repeat (5) step();
    resp_ready = 1'b1;
    step();
    check("t4_r", got_r, 32'd3);
    #1;
    check("t4_rdy1", 32'(req1_ready), 32'd1);
    wait_resp(20);
    check("t4_r1", got_r, 32'd3);

    set_req(0, ADD, 32'd100, 32'd1);
    for (int i = 0; i < 10 && !acc_any; i++) step();
    step();
    do_reset();
    repeat (8) step();
    set_req(1, SUB, 32'd20, 32'd5);
    wait_resp(20);
    check("t5_r", got_r, 32'd15);
    check("t5_id", 32'(got_id), 32'd1);

    repeat (3000) begin
      if (req0_valid) begin
        if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
      end else if ($urandom_range(0, 1) == 1) rand_req(0);
      if (req1_valid) begin
        if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
      end else if ($urandom_range(0, 1) == 1) rand_req(1);
      resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
